bus_memory_responder: RTL

- Memory-side responder for the CPU external bus; the opposite end of the CPU's address/data, tag, address-strobe, read and write outputs.
- Captures addresses, stores 64-bit data words with 8-bit tags, and returns data and tag to the CPU i_data/i_tag inputs at a fixed read latency.
- Used by the CPU testbenches as system memory in place of the behavioural array.
- The bus has no ready line, so all timing is fixed and parameterised.

---
 rtl/bus_memory_responder.sv | 82 ++++++++
 1 files changed

// File: rtl/bus_memory_responder.sv
// bus_memory_responder: CPU external-bus memory with fixed-latency pipelined reads.
// Define BUS_CHECK_EN to add the bus_err protocol checker and err_cnt counter.
module bus_memory_responder #(
  parameter int AW     = 16,
  parameter int RD_LAT = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [63:0] bus_ad,
  input  logic [7:0]  bus_tag,
  input  logic        bus_astb,
  input  logic        bus_rd,
  input  logic        bus_wr,
  output logic [63:0] rd_data,
  output logic [7:0]  rd_tag,
`ifdef BUS_CHECK_EN
  output logic        bus_err,
`endif
  output logic        rd_valid
);
  logic [AW-1:0] ar, ea;
  logic rd_acc, wr_acc, inc;
  logic [71:0] mem [2**AW];
  logic [RD_LAT-1:0] vld, vin;
  logic [71:0] pipe [RD_LAT];
  logic [71:0] din [RD_LAT];
  // A write with astb is dropped (bus_ad holds an address); a write beats a read.
  always_comb begin
    ea = bus_astb ? bus_ad[AW-1:0] : ar;
    rd_acc = bus_rd & ~bus_wr;
    wr_acc = bus_wr & ~bus_astb;
    inc = (bus_rd | bus_wr) & ~(bus_wr & bus_astb);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) ar <= '0;
    else if (bus_astb | inc) ar <= ea + AW'(inc);
  always_ff @(posedge clk)
    if (wr_acc) mem[ar] <= {bus_tag, bus_ad};
  // Stage 0 samples the array; each stage only loads on a valid beat so the
  // final stage holds the last returned word while rd_valid is low.
  always_comb begin
    vin[0] = rd_acc;
    din[0] = mem[ea];
    for (int i = 1; i < RD_LAT; i++) begin
      vin[i] = vld[i-1];
      din[i] = pipe[i-1];
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      vld <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
    end else begin
      vld <= vin;
      for (int i = 0; i < RD_LAT; i++) if (vin[i]) pipe[i] <= din[i];
    end
  assign rd_valid = vld[RD_LAT-1];
  assign {rd_tag, rd_data} = pipe[RD_LAT-1];
`ifdef BUS_CHECK_EN
  typedef enum logic [1:0] {IDLE, ADDR, XFER} state_t;
  state_t state, state_nx;
  logic err_now;
  logic [7:0] err_cnt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = bus_astb ? ADDR : (state == ADDR && (bus_rd | bus_wr)) ? XFER : state;
  always_comb
    err_now = (bus_rd & bus_wr) | (bus_wr & bus_astb)
            | (state == IDLE && (bus_rd | bus_wr) && !bus_astb)
            | (state != IDLE && inc && ea == '1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      bus_err <= 1'b0;
      err_cnt <= '0;
    end else if (err_now) begin
      bus_err <= 1'b1;
      err_cnt <= err_cnt + {7'd0, ~&err_cnt};
    end
`endif
endmodule
